// File: rtl/imem_port.sv
// Instruction memory responder for the fetch unit.
// Word-addressed synchronous storage with an optional fixed number of wait
// states per fetch, a registered busy (stall) flag, a fault flag for
// misaligned / out-of-range fetches and a loader write port.
module imem_port #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic            abort,
    output logic [XLEN-1:0] data,
    output logic            busy,
    output logic            fault,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int              IDXW      = $clog2(DEPTH_WORDS);
    // Byte span of the storage, one bit wider than XLEN so it cannot wrap.
    localparam logic [XLEN:0]   LIMIT_OFF = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [3:0]      WAIT_CNT  = 4'(WAIT_CYCLES);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

    // Aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS); off = a - BASE_ADDR.
    function automatic logic addr_ok(input logic [XLEN-1:0] a, input logic [XLEN-1:0] off);
        addr_ok = (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, off} < LIMIT_OFF);
    endfunction

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] req_q, req_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] rd_addr_s;
    logic [XLEN-1:0] rd_off_s;
    logic [IDXW-1:0] rd_idx_s;
    logic            rd_ok_s;
    logic [XLEN-1:0] rd_word_s;
    logic [XLEN-1:0] wr_off_s;
    logic [IDXW-1:0] wr_idx_s;
    logic            wr_hit_s;

    assign rd_off_s = rd_addr_s - BASE_ADDR;
    assign rd_idx_s = rd_off_s[IDXW+1:2];
    assign rd_ok_s  = addr_ok(rd_addr_s, rd_off_s);
    assign wr_off_s = wr_addr - BASE_ADDR;
    assign wr_idx_s = wr_off_s[IDXW+1:2];
    assign wr_hit_s = wr_en && addr_ok(wr_addr, wr_off_s);

    // Read address: live bus in READY, the latched request while waiting.
    always_comb begin
        rd_addr_s = addr;
        if (state_q == ST_WAIT) begin
            rd_addr_s = req_q;
        end else begin
            rd_addr_s = addr;
        end
    end

    // Read word with write-first bypass when the loader hits the same word.
    always_comb begin
        rd_word_s = mem_q[rd_idx_s];
        if (wr_hit_s && (wr_idx_s == rd_idx_s)) begin
            rd_word_s = wr_data;
        end else begin
            rd_word_s = mem_q[rd_idx_s];
        end
    end

    // Fetch FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        busy_d  = busy_q;
        fault_d = fault_q;
        if (abort) begin
            state_d = ST_READY;
            cnt_d   = 4'd0;
            data_d  = NOP_WORD;
            fault_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (WAIT_CYCLES == 0) begin
                        data_d  = rd_ok_s ? rd_word_s : NOP_WORD;
                        fault_d = !rd_ok_s;
                        busy_d  = 1'b0;
                    end else begin
                        req_d   = addr;
                        cnt_d   = WAIT_CNT;
                        state_d = ST_WAIT;
                        busy_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        data_d  = rd_ok_s ? rd_word_s : NOP_WORD;
                        fault_d = !rd_ok_s;
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_READY;
                    cnt_d   = 4'd0;
                    data_d  = NOP_WORD;
                    fault_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_READY;
            cnt_q   <= 4'd0;
            req_q   <= BASE_ADDR;
            data_q  <= NOP_WORD;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // Loader writes; storage is deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    assign data  = data_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_imem_port.sv
// Directed bench for imem_port: vector table on a zero-wait instance, plus
// hand sequences on two-wait and three-wait instances.
module tb_imem_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr0 = 32'h0, wr_addr0 = 32'h0, wr_data0 = 32'h0, data0;
    logic        abort0 = 1'b0, wr_en0 = 1'b0, busy0, fault0;
    logic [31:0] addr2 = 32'h0, wr_addr2 = 32'h0, wr_data2 = 32'h0, data2;
    logic        abort2 = 1'b0, wr_en2 = 1'b0, busy2, fault2;
    logic [31:0] addr3 = 32'h0, wr_addr3 = 32'h0, wr_data3 = 32'h0, data3;
    logic        abort3 = 1'b0, wr_en3 = 1'b0, busy3, fault3;

    imem_port #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .addr(addr0), .abort(abort0), .data(data0),
        .busy(busy0), .fault(fault0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0)
    );
    imem_port #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .addr(addr2), .abort(abort2), .data(data2),
        .busy(busy2), .fault(fault2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
    );
    imem_port #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .addr(addr3), .abort(abort3), .data(data3),
        .busy(busy3), .fault(fault3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        abort;
        logic        wr_en;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_fault;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load(input int which, input logic [31:0] a, input logic [31:0] d);
        case (which)
            0: begin wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d; end
            2: begin wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d; end
            default: begin wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = d; end
        endcase
        tick();
        wr_en0 = 1'b0;
        wr_en2 = 1'b0;
        wr_en3 = 1'b0;
    endtask

    initial begin
        //        addr          abort wr   wr_addr       wr_data       exp_data      busy  fault
        vecs[0]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11,        1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0,        32'h0,        32'h22,        1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0008, 1'b0, 1'b0, 32'h0,        32'h0,        32'h33,        1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0008, 1'b0, 1'b0, 32'h0,        32'h0,        32'h33,        1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0006, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,           1'b0, 1'b1};
        vecs[5]  = '{32'h0000_000C, 1'b0, 1'b0, 32'h0,        32'h0,        32'h44,        1'b0, 1'b0};
        vecs[6]  = '{32'h0000_4000, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,           1'b0, 1'b1};
        vecs[7]  = '{32'h0000_0004, 1'b1, 1'b0, 32'h0,        32'h0,        NOP,           1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0008, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0055, 32'h11,        1'b0, 1'b0};
        vecs[10] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,        32'h0,        32'h11,        1'b0, 1'b0};
        vecs[11] = '{32'h0000_3FFC, 1'b0, 1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0};
        vecs[12] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,           1'b0, 1'b1};
        vecs[13] = '{32'h0000_0008, 1'b0, 1'b0, 32'h0,        32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("reset data", data0, NOP);
        check("reset busy", {31'd0, busy2}, 32'd0);
        check("reset fault", {31'd0, fault3}, 32'd0);
        rst = 1'b1;
        tick();

        // Zero-wait instance: preload then table.
        load(0, 32'h0, 32'h11);
        load(0, 32'h4, 32'h22);
        load(0, 32'h8, 32'h33);
        load(0, 32'hC, 32'h44);
        for (int i = 0; i < NVEC; i++) begin
            addr0    = vecs[i].addr;
            abort0   = vecs[i].abort;
            wr_en0   = vecs[i].wr_en;
            wr_addr0 = vecs[i].wr_addr;
            wr_data0 = vecs[i].wr_data;
            tick();
            check($sformatf("vec%0d data", i), data0, vecs[i].exp_data);
            check($sformatf("vec%0d busy", i), {31'd0, busy0}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d fault", i), {31'd0, fault0}, {31'd0, vecs[i].exp_fault});
        end
        abort0 = 1'b0;
        wr_en0 = 1'b0;

        // Two-wait instance.
        load(2, 32'h4, 32'h22);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        check("w2 abort busy", {31'd0, busy2}, 32'd0);
        check("w2 abort data", data2, NOP);
        addr2 = 32'h4;
        tick();
        check("w2 edge0 busy", {31'd0, busy2}, 32'd1);
        check("w2 edge0 data", data2, NOP);
        addr2 = 32'h8;
        tick();
        check("w2 edge1 busy", {31'd0, busy2}, 32'd1);
        tick();
        check("w2 edge2 busy", {31'd0, busy2}, 32'd0);
        check("w2 edge2 data", data2, 32'h22);
        check("w2 edge2 fault", {31'd0, fault2}, 32'd0);
        addr2 = 32'h6;
        ticks(3);
        check("w2 misalign data", data2, NOP);
        check("w2 misalign fault", {31'd0, fault2}, 32'd1);
        addr2 = 32'h4;
        ticks(3);
        check("w2 refetch data", data2, 32'h22);
        check("w2 refetch fault", {31'd0, fault2}, 32'd0);
        tick();
        load(2, 32'h4, 32'h77);
        tick();
        check("w2 wr-in-wait data", data2, 32'h77);

        // Three-wait instance.
        load(3, 32'h8, 32'h33);
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        addr3 = 32'h8;
        ticks(2);
        check("w3 pre-abort busy", {31'd0, busy3}, 32'd1);
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        check("w3 abort busy", {31'd0, busy3}, 32'd0);
        check("w3 abort data", data3, NOP);
        ticks(3);
        check("w3 after3 busy", {31'd0, busy3}, 32'd1);
        tick();
        check("w3 done busy", {31'd0, busy3}, 32'd0);
        check("w3 done data", data3, 32'h33);

        // Asynchronous reset in the middle of a wait.
        tick();
        check("w3 wait busy", {31'd0, busy3}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst busy", {31'd0, busy3}, 32'd0);
        check("rst data", data3, NOP);
        check("rst fault", {31'd0, fault3}, 32'd0);
        ticks(2);
        rst = 1'b1;
        ticks(4);
        check("w3 retained data", data3, 32'h33);
        addr0 = 32'h4;
        tick();
        check("w0 retained data", data0, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
